sample_streamer: RTL
====================

// Module: sample_streamer
// PURPOSE
//   Playback front end for the synthesiser. Issues word reads to the cellular-RAM
//   memory controller, walking from START_ADDR to END_ADDR. Buffers the returned
//   16-bit samples in a small FIFO. Releases one 8-bit unsigned sample per
//   sample tick to the DAC/PWM stage, driving phase/s.
// PARAMETERS
//   ADDR_W      23   word address width (matches controller AddressIn)
//   DATA_W      16   controller read-data width
//   OUT_W       8    output sample width
//   FIFO_DEPTH  8    sample buffer entries (power of 2, >=2)
//   TICK_DIV    2272 clk cycles per output sample (100 MHz / 2272 ~ 44.0 kHz)
// PORTS
//   clk          in   1       system clock
//   rst          in   1       synchronous, active-high reset
//   start        in   1       1-cycle pulse: begin playback at start_addr
//   stop         in   1       1-cycle pulse: abort playback
//   loop         in   1       1: wrap to start_addr after end_addr; 0: one-shot
//   start_addr   in   ADDR_W  first word address (sampled on start)
//   end_addr     in   ADDR_W  last word address, inclusive (sampled on start)
//   mem_req      out  1       read request to memory controller
//   mem_addr     out  ADDR_W  read address, stable while mem_req=1
//   mem_ack      in   1       1-cycle pulse: mem_rdata valid, request complete
//   mem_rdata    in   DATA_W  read data (two's-complement sample)
//   sample       out  OUT_W   current output sample (unsigned, offset binary)
//   sample_stb   out  1       1-cycle pulse when sample updates
//   busy         out  1       playback active (FSM not IDLE)
//   underrun     out  1       sticky: tick occurred with FIFO empty while busy
// BEHAVIOUR
//   Reset: mem_req=0, mem_addr=0, sample=8'h80 (midscale), sample_stb=0,
//     busy=0, underrun=0, FIFO empty, tick counter=0, FSM=IDLE. Takes effect
//     in the same edge, also mid-request; a pending ack afterwards is ignored.
//   Tick counter: free-runs 0..TICK_DIV-1; tick=1 on the cycle count==TICK_DIV-1.
//   FSM states: IDLE, FETCH (mem_req=1), WAIT_SPACE, DRAIN.
//     IDLE: on start -> latch addrs, cur=start_addr, clear FIFO and underrun,
//       -> FETCH.
//     FETCH: mem_req=1, mem_addr=cur held constant. On mem_ack: push
//       mem_rdata. If cur==end_addr: loop=1 -> cur=start_addr; loop=0 ->
//       DRAIN. Else cur=cur+1 (wraps mod 2^ADDR_W). Next state FETCH if FIFO
//       count after push < FIFO_DEPTH, else WAIT_SPACE.
//     WAIT_SPACE: -> FETCH once count < FIFO_DEPTH.
//     DRAIN: no requests; -> IDLE when FIFO empty.
//     At most one outstanding request; mem_req falls the cycle after mem_ack.
//   Output: on tick with busy=1 and FIFO non-empty, pop the head word w.
//     sample <= w[DATA_W-1 -: OUT_W] ^ (1<<(OUT_W-1)) (sign flip to unsigned).
//     sample_stb=1 on the following cycle, i.e. 1 clk after tick.
//     Tick with FIFO empty while busy: sample holds, no stb, underrun <= 1.
//     In IDLE: sample holds last value; no stb.
//   Simultaneous push and pop: count unchanged; both take effect.
//   Push into a full FIFO cannot occur (request gating); assert in sim.
//   stop (any state): mem_req held until the outstanding ack (data discarded),
//     then FIFO flushed -> IDLE. stop has priority over start in the same cycle.
//   start while busy: ignored.
//   end_addr < start_addr: illegal; behaviour is address wrap, not checked.
// TESTING
//   1 rst, start_addr=0x10, end_addr=0x13, loop=0, ack 2 clk after req ->
//     reads 0x10..0x13 once; 4 sample_stb; busy falls after 4th pop.
//   2 Data 0x7F00,0x8000,0x0000 -> sample 0xFF,0x00,0x80 on successive stb.
//   3 loop=1, range 0x0..0x2 -> mem_addr sequence 0,1,2,0,1,2...; no underrun.
//   4 ack latency 20 clk, TICK_DIV=4 -> FIFO empties; underrun=1, sample holds.
//   5 Fill FIFO (8 entries, slow ticks) -> mem_req stays 0 until first pop,
//     then exactly one new request.
//   6 stop mid-FETCH, then rst asserted mid-request -> mem_req=0, busy=0,
//     sample=0x80 after reset edge; late ack causes no push.

Source files
------------

// File: rtl/sample_streamer_if.sv
// Read port between the sample streamer and the cellular-RAM controller.
// One outstanding word read at a time; mem_ack pulses once per completed request.
interface sample_streamer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/sample_streamer.sv
// Playback front end: walks a word-address range in the cellular RAM, buffers samples,
// and releases one offset-binary sample per tick to the DAC/PWM stage.
module sample_streamer #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 2272
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    sample_streamer_if.master   mem,
    output logic [OUT_W-1:0]    sample,
    output logic                sample_stb,
    output logic                busy,
    output logic                underrun
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TCNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);
    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [OUT_W-1:0]  MID       = {1'b1, {(OUT_W-1){1'b0}}};

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] FETCH      = 2'd1;
    localparam logic [1:0] WAIT_SPACE = 2'd2;
    localparam logic [1:0] DRAIN      = 2'd3;

    logic [1:0]        state;
    logic              stopping;
    logic              req;
    logic [ADDR_W-1:0] cur, startLat, endLat;
    logic [OUT_W-1:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count, countNext;
    logic [TCNT_W-1:0] tickCnt;
    logic              tick, accept, push, pop, startGo, holdStop, endStop, flush;
    logic              unusedLowBits;

    assign mem.mem_req  = req;
    assign mem.mem_addr = cur;
    assign busy         = (state != IDLE);

    // Only the top OUT_W bits of each word reach the DAC.
    assign unusedLowBits = ^mem.mem_rdata[DATA_W-OUT_W-1:0];

    assign tick     = (tickCnt == TICK_LAST);
    // An ack with no request in flight (e.g. left over from a reset) is ignored.
    assign accept   = req && mem.mem_ack;
    assign push     = accept && !stopping && !stop;
    assign pop      = tick && busy && (count != '0);
    assign startGo  = (state == IDLE) && start && !stop;
    // A stop with a read in flight waits for its ack; otherwise it ends playback now.
    assign holdStop = busy && stop && req && !mem.mem_ack;
    assign endStop  = busy && ((stop && !(req && !mem.mem_ack)) || (stopping && accept));
    assign flush    = endStop || startGo;
    assign countNext = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            assert (count != FULL);
            fifoMem[wrPtr] <= mem.mem_rdata[DATA_W-1 -: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stopping   <= 1'b0;
            req        <= 1'b0;
            cur        <= '0;
            startLat   <= '0;
            endLat     <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            tickCnt    <= '0;
            sample     <= MID;
            sample_stb <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tickCnt    <= tick ? '0 : tickCnt + 1'b1;
            sample_stb <= pop;
            if (pop) sample <= fifoMem[rdPtr] ^ MID;
            if (tick && busy && count == '0) underrun <= 1'b1;

            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + 1'b1;
                if (pop)  rdPtr <= rdPtr + 1'b1;
                count <= countNext;
            end

            if (endStop) begin
                state    <= IDLE;
                req      <= 1'b0;
                stopping <= 1'b0;
            end else begin
                if (holdStop) stopping <= 1'b1;
                case (state)
                    IDLE: if (startGo) begin
                        startLat <= start_addr;
                        endLat   <= end_addr;
                        cur      <= start_addr;
                        underrun <= 1'b0;
                        state    <= FETCH;
                    end
                    FETCH: if (!req) begin
                        req <= 1'b1;
                    end else if (accept) begin
                        // Drop req for a cycle so each read is a distinct request.
                        req   <= 1'b0;
                        state <= (countNext < FULL) ? FETCH : WAIT_SPACE;
                        if (cur == endLat) begin
                            if (loop) cur   <= startLat;
                            else      state <= DRAIN;
                        end else begin
                            cur <= cur + 1'b1;
                        end
                    end
                    WAIT_SPACE: if (count < FULL) state <= FETCH;
                    DRAIN:      if (count == '0)  state <= IDLE;
                    default:    state <= IDLE;
                endcase
            end
        end
    end
endmodule
